window_position_scanner: RTL and testbench
==========================================

Name: window_position_scanner

Overview:
- Sequential traversal stage directly downstream of the window-column decoder in the SAD main path.
- Consumes the decoder's 2-bit column-size select (0=4, 1=8, 2=16) plus frame and window dimensions.
- Walks every legal top-left window position across the frame and emits row/column indices and the byte address of each position.
- Uses a valid/ready handshake toward the frame-load ALUs; the address is built incrementally, with no multiplier.

Parameters:
- DIM_W, 16, width of row/column counters and the internal dimension registers.
- ADDR_W, 32, width of the address path.
- WORD_SHIFT, 2, log2 of bytes per frame element; the byte offset is the element offset shifted left by this amount.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- frame_base  in  ADDR_W  byte address of frame element (0,0).
- frame_rows  in  32  frame height in elements; the low DIM_W bits are used.
- frame_cols  in  32  frame width in elements; the low DIM_W bits are used.
- window_rows  in  32  window height in elements; the low DIM_W bits are used.
- wcol_sel  in  2  window-column select from the decoder: 0=4, 1=8, 2=16, 3=invalid.
- pos_ready  in  1  consumer accepts the current position.
- pos_valid  out  1  current position is valid.
- pos_row  out  DIM_W  window top-left row.
- pos_col  out  DIM_W  window top-left column.
- pos_addr  out  ADDR_W  frame_base + ((pos_row*frame_cols + pos_col) << WORD_SHIFT).
- pos_last  out  1  current position is the final one of the scan.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when a scan ends, normally or on error.
- err  out  1  configuration error; held until the next accepted start.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State returns to IDLE.
  - All outputs go to 0, including err. All internal registers clear.
  - Reset may occur mid-scan; after release, no position is emitted until a new start.
- States: IDLE, SCAN, DONE.
- IDLE, on start=1:
  - Latch all inputs and decode wcol to 4, 8 or 16.
  - Clear err.
  - Compute max_row = frame_rows - window_rows and max_col = frame_cols - wcol.
  - Error case: go to DONE with err=1 and emit no positions if any of these hold: wcol_sel=3; window_rows=0; window_rows>frame_rows; wcol>frame_cols.
  - Otherwise go to SCAN with row=0, col=0, row_base=frame_base.
- start while not in IDLE: ignored.
- SCAN output timing:
  - pos_valid=1 starting the cycle after start is sampled (latency 1).
  - pos_row, pos_col, pos_addr and pos_last are registered.
  - While pos_valid=1 and pos_ready=0, these outputs hold stable.
- SCAN, on handshake (pos_valid & pos_ready):
  - If pos_last: go to DONE, and pos_valid drops the next cycle.
  - Else if col<max_col: col+1, addr += 1<<WORD_SHIFT.
  - Else: row+1, col=0, row_base += frame_cols<<WORD_SHIFT, addr = new row_base.
- pos_last = (row==max_row) & (col==max_col). When the window equals the frame, the first position is also the last.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start arriving in the DONE cycle is ignored.
- Arithmetic:
  - Address arithmetic is unsigned modulo 2^ADDR_W.
  - Dimension comparisons are unsigned on DIM_W bits.
- Throughput: one position per cycle when pos_ready is held high.

Optional Feature:
- Macro: SERPENTINE_SCAN_EN.
- Defined:
  - Odd rows traverse columns from max_col down to 0: col-1 and addr -= 1<<WORD_SHIFT.
  - A row change keeps col at its end value and moves the address by frame_cols<<WORD_SHIFT.
  - pos_last is at (max_row, 0) when max_row is odd, otherwise at (max_row, max_col).
- Not defined: pure raster order, as described in Behaviour.

Test Plan:
- Raster scan, no backpressure. frame_base=0x100, frame 6x6, window_rows=4, wcol_sel=0, pos_ready=1.
  -> 9 positions (0,0),(0,1),(0,2),(1,0)…(2,2) on consecutive cycles.
  -> Addresses 0x100, 0x104, 0x108, 0x118 … 0x138.
  -> pos_last only on (2,2); done pulses one cycle after it; err=0.
- Backpressure. Same setup; hold pos_ready=0 for 3 cycles while (0,1) is presented.
  -> (0,1) with addr 0x104 is held stable for those cycles; the next position is (0,2) once pos_ready is raised.
- Single position. Frame 8x8, window_rows=8, wcol_sel=1.
  -> One position (0,0) at frame_base with pos_last=1; then done.
- Error cases.
  -> wcol_sel=3: done=1 and err=1 on the cycle after start; pos_valid never rises.
  -> frame_cols=12 with wcol_sel=2: same response.
- Reset mid-scan. Assert Reset_n=0 while at (1,1).
  -> All outputs go to 0 immediately; after release, nothing is emitted until a new start.
  -> A new start restarts the scan at (0,0).
- Serpentine (SERPENTINE_SCAN_EN defined). Run the 6x6 case from the first scenario.
  -> Row 1 order is (1,2),(1,1),(1,0) with addresses 0x120, 0x11C, 0x118.
  -> pos_last is on (2,2).

Source files
------------

// File: rtl/window_position_scanner.sv
// Walks every legal top-left window position of a frame and emits row/col and byte address.
// Optional macro SERPENTINE_SCAN_EN: odd rows are traversed right-to-left (boustrophedon order).
module window_position_scanner #(
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_SHIFT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [31:0]       frame_rows,
  input  logic [31:0]       frame_cols,
  input  logic [31:0]       window_rows,
  input  logic [1:0]        wcol_sel,
  input  logic              pos_ready,
  output logic              pos_valid,
  output logic [DIM_W-1:0]  pos_row,
  output logic [DIM_W-1:0]  pos_col,
  output logic [ADDR_W-1:0] pos_addr,
  output logic              pos_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [DIM_W-1:0]  max_row_q, max_row_d, max_col_q, max_col_d;
  logic [DIM_W-1:0]  end_col_q, end_col_d, fcols_q, fcols_d;
  logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic              last_q, last_d, err_q, err_d;

  logic [DIM_W-1:0]  in_frows, in_fcols, in_wrows, in_wcol;
  logic [DIM_W-1:0]  in_max_row, in_max_col, in_end_col;
  logic [ADDR_W-1:0] word_step, row_step;
  logic              cfg_bad;
  logic              unused_in;

  assign in_frows  = frame_rows[DIM_W-1:0];
  assign in_fcols  = frame_cols[DIM_W-1:0];
  assign in_wrows  = window_rows[DIM_W-1:0];
  assign unused_in = ^{frame_rows[31:DIM_W], frame_cols[31:DIM_W], window_rows[31:DIM_W]};

  always_comb begin
    case (wcol_sel)
      2'd0:    in_wcol = DIM_W'(4);
      2'd1:    in_wcol = DIM_W'(8);
      2'd2:    in_wcol = DIM_W'(16);
      default: in_wcol = '0;
    endcase
  end

  assign cfg_bad    = (wcol_sel == 2'd3) || (in_wrows == '0) || (in_wrows > in_frows) ||
                      (in_wcol > in_fcols);
  assign in_max_row = in_frows - in_wrows;
  assign in_max_col = in_fcols - in_wcol;
`ifdef SERPENTINE_SCAN_EN
  // The final row ends at column 0 when it is traversed right-to-left.
  assign in_end_col = in_max_row[0] ? '0 : in_max_col;
`else
  assign in_end_col = in_max_col;
`endif

  assign word_step = ADDR_W'(1) << WORD_SHIFT;
  assign row_step  = ADDR_W'(fcols_q) << WORD_SHIFT;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    max_row_d  = max_row_q;
    max_col_d  = max_col_q;
    end_col_d  = end_col_q;
    fcols_d    = fcols_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    last_d     = last_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d      = cfg_bad;
          max_row_d  = in_max_row;
          max_col_d  = in_max_col;
          end_col_d  = in_end_col;
          fcols_d    = in_fcols;
          row_d      = '0;
          col_d      = '0;
          addr_d     = frame_base;
          row_base_d = frame_base;
          last_d     = !cfg_bad && (in_max_row == '0) && (in_end_col == '0);
          state_d    = cfg_bad ? StDone : StScan;
        end
      end
      StScan: begin
        if (pos_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = StDone;
          end else begin
`ifdef SERPENTINE_SCAN_EN
            if (row_q[0] ? (col_q != '0) : (col_q < max_col_q)) begin
              col_d  = row_q[0] ? col_q - 1'b1 : col_q + 1'b1;
              addr_d = row_q[0] ? addr_q - word_step : addr_q + word_step;
            end else begin
              row_d      = row_q + 1'b1;
              row_base_d = row_base_q + row_step;
              addr_d     = addr_q + row_step;
            end
`else
            if (col_q < max_col_q) begin
              col_d  = col_q + 1'b1;
              addr_d = addr_q + word_step;
            end else begin
              row_d      = row_q + 1'b1;
              col_d      = '0;
              row_base_d = row_base_q + row_step;
              addr_d     = row_base_d;
            end
`endif
            last_d = (row_d == max_row_q) && (col_d == end_col_q);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      max_row_q  <= '0;
      max_col_q  <= '0;
      end_col_q  <= '0;
      fcols_q    <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      max_row_q  <= max_row_d;
      max_col_q  <= max_col_d;
      end_col_q  <= end_col_d;
      fcols_q    <= fcols_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign pos_valid = (state_q == StScan);
  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);
  assign pos_row   = row_q;
  assign pos_col   = col_q;
  assign pos_addr  = addr_q;
  assign pos_last  = last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_window_position_scanner.sv
// Directed, table-driven bench for window_position_scanner (raster or serpentine build).
module tb_window_position_scanner;

  logic        Clk, Reset_n, start, pos_ready;
  logic [31:0] frame_base, frame_rows, frame_cols, window_rows;
  logic [1:0]  wcol_sel;
  logic        pos_valid, pos_last, busy, done, err;
  logic [15:0] pos_row, pos_col;
  logic [31:0] pos_addr;

  window_position_scanner #(.DIM_W(16), .ADDR_W(32), .WORD_SHIFT(2)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .frame_base  (frame_base),
    .frame_rows  (frame_rows),
    .frame_cols  (frame_cols),
    .window_rows (window_rows),
    .wcol_sel    (wcol_sel),
    .pos_ready   (pos_ready),
    .pos_valid   (pos_valid),
    .pos_row     (pos_row),
    .pos_col     (pos_col),
    .pos_addr    (pos_addr),
    .pos_last    (pos_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic [15:0] row;
    logic [15:0] col;
    logic [31:0] addr;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;
    logic        chk_pos;
  } vec_t;

  int nvec = 0;
  int nfail = 0;
  vec_t tbl[11];
  int   exp_row[9];
  int   exp_col[9];
  logic [31:0] exp_addr[9];

  function automatic vec_t mk(input logic s, input logic r, input logic val, input int row,
                              input int col, input logic [31:0] a, input logic l, input logic b,
                              input logic d, input logic e, input logic c);
    vec_t x;
    x.start = s; x.ready = r; x.valid = val; x.row = 16'(row); x.col = 16'(col);
    x.addr = a; x.last = l; x.busy = b; x.done = d; x.err = e; x.chk_pos = c;
    return x;
  endfunction

  task automatic check(input string name, input vec_t x);
    logic bad;
    bad = (pos_valid !== x.valid) || (pos_last !== x.last) || (busy !== x.busy) ||
          (done !== x.done) || (err !== x.err);
    if (x.chk_pos)
      bad = bad || (pos_row !== x.row) || (pos_col !== x.col) || (pos_addr !== x.addr);
    nvec++;
    if (bad) begin
      nfail++;
      $display("FAIL %s: got v=%0b r=%0d c=%0d a=%h l=%0b b=%0b d=%0b e=%0b, expected v=%0b r=%0d c=%0d a=%h l=%0b b=%0b d=%0b e=%0b (pos checked=%0b)",
               name, pos_valid, pos_row, pos_col, pos_addr, pos_last, busy, done, err,
               x.valid, x.row, x.col, x.addr, x.last, x.busy, x.done, x.err, x.chk_pos);
    end
  endtask

  task automatic apply(input string name, input vec_t x);
    @(negedge Clk);
    start     = x.start;
    pos_ready = x.ready;
    @(posedge Clk);
    #1;
    check(name, x);
  endtask

  task automatic set_cfg(input logic [31:0] b, input int fr, input int fc, input int wr,
                         input logic [1:0] sel);
    frame_base = b; frame_rows = 32'(fr); frame_cols = 32'(fc); window_rows = 32'(wr);
    wcol_sel = sel;
  endtask

  vec_t zero_v;
  vec_t hold_v;

  initial begin
    Reset_n = 1'b0; start = 1'b0; pos_ready = 1'b0;
    set_cfg(32'h0, 0, 0, 0, 2'd0);
    zero_v = mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);

    // 6x6 frame, 4x4 window: max_row = max_col = 2, row stride 0x18
`ifdef SERPENTINE_SCAN_EN
    exp_row = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    exp_col = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h120, 32'h11C, 32'h118,
                 32'h130, 32'h134, 32'h138};
`else
    exp_row = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    exp_col = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h118, 32'h11C, 32'h120,
                 32'h130, 32'h134, 32'h138};
`endif
    tbl[0] = mk(1, 1, 1, 0, 0, 32'h100, 0, 1, 0, 0, 1);
    for (int k = 1; k < 9; k++)
      tbl[k] = mk(0, 1, 1, exp_row[k], exp_col[k], exp_addr[k], (k == 8), 1, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);

    #1;
    check("reset", zero_v);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Full scan, no backpressure
    set_cfg(32'h100, 6, 6, 4, 2'd0);
    for (int i = 0; i < 11; i++) apply($sformatf("scan[%0d]", i), tbl[i]);

    // Backpressure while (0,1) is presented
    apply("bp_start", tbl[0]);
    apply("bp_pos1", tbl[1]);
    hold_v = tbl[1];
    hold_v.ready = 1'b0;
    for (int i = 0; i < 3; i++) apply($sformatf("bp_hold[%0d]", i), hold_v);
    for (int i = 2; i < 11; i++) apply($sformatf("bp_drain[%0d]", i), tbl[i]);

    // Invalid column select
    set_cfg(32'h100, 6, 6, 4, 2'd3);
    apply("err_sel3", mk(1, 1, 0, 0, 0, 32'h0, 0, 0, 1, 1, 0));
    apply("err_sel3_hold", mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0));
    // 16-wide window on a 12-wide frame
    set_cfg(32'h100, 6, 12, 4, 2'd2);
    apply("err_wide", mk(1, 1, 0, 0, 0, 32'h0, 0, 0, 1, 1, 0));
    apply("err_wide_hold", mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0));
    // Zero-height window
    set_cfg(32'h100, 6, 6, 0, 2'd0);
    apply("err_rows0", mk(1, 1, 0, 0, 0, 32'h0, 0, 0, 1, 1, 0));
    apply("err_rows0_hold", mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0));

    // Window equals frame: single position, also clears err
    set_cfg(32'h2000, 8, 8, 8, 2'd1);
    apply("single_pos", mk(1, 0, 1, 0, 0, 32'h2000, 1, 1, 0, 0, 1));
    apply("single_stall", mk(0, 0, 1, 0, 0, 32'h2000, 1, 1, 0, 0, 1));
    apply("single_done", mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0));
    apply("single_idle", mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));

    // Reset at (1,1)
    set_cfg(32'h100, 6, 6, 4, 2'd0);
    for (int i = 0; i < 5; i++) apply($sformatf("rst_pre[%0d]", i), tbl[i]);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("rst_async", zero_v);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) apply($sformatf("rst_quiet[%0d]", i), zero_v);
    apply("rst_restart", tbl[0]);
    apply("rst_restart_pos1", tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
